// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: address width,
// reset vector and the 2-bit FSM state encoding.
package fetch_ctrl_pkg;

  localparam int          FC_XLEN     = 64;
  localparam logic [63:0] FC_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fc_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch FSM: requests a word at pc, holds the
// returned instruction for decode, and squashes responses made stale by redirects.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int               XLEN     = FC_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = FC_RESET_PC[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            busy
);

  fc_state_t       state;
  logic [XLEN-1:0] pc;
  logic            squash;
  logic [XLEN-1:0] target;

  // Redirect targets are forced to word alignment.
  assign target = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      squash   <= 1'b0;
      out_inst <= '0;
      out_pc   <= '0;
    end else begin
      if (redirect_valid)
        pc <= target;
      else if (state == ST_HOLD && out_ready)
        pc <= pc + XLEN'(4);

      unique case (state)
        ST_IDLE: begin
          if (fetch_en && !redirect_valid)
            state <= ST_REQ;
        end
        ST_REQ: begin
          if (mem_gnt) begin
            state  <= ST_WAIT;
            squash <= redirect_valid;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            // A redirect arriving with the data also makes the data stale.
            if (squash || redirect_valid) begin
              squash <= 1'b0;
              state  <= fetch_en ? ST_REQ : ST_IDLE;
            end else begin
              out_inst <= mem_rdata;
              out_pc   <= pc;
              state    <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            squash <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid)
            state <= ST_REQ;
          else if (out_ready)
            state <= fetch_en ? ST_REQ : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = (state == ST_REQ);
  assign mem_addr  = pc;
  assign out_valid = (state == ST_HOLD);
  assign busy      = (state == ST_REQ) || (state == ST_WAIT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level reference model checked
// every cycle, plus hand-computed expectations at each scenario's key points.
module tb_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "requesting", "awaiting data", "holding for decode",
  // plus a stale-response flag; nothing set means idle.
  bit          m_requesting, m_awaiting, m_holding, m_stale;
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_inst;

  always @(posedge clk or negedge rst_n) begin
    logic [63:0] next_pc;
    if (!rst_n) begin
      m_requesting = 0; m_awaiting = 0; m_holding = 0; m_stale = 0;
      m_pc = RST_PC; m_ipc = '0; m_inst = '0;
    end else begin
      next_pc = m_pc;
      if (redirect_valid)              next_pc = {redirect_pc[63:2], 2'b00};
      else if (m_holding && out_ready) next_pc = m_pc + 64'd4;

      if (m_requesting) begin
        if (mem_gnt) begin
          m_requesting = 0; m_awaiting = 1; m_stale = redirect_valid;
        end
      end else if (m_awaiting) begin
        if (mem_rvalid) begin
          m_awaiting = 0;
          if (m_stale || redirect_valid) begin
            m_stale = 0; m_requesting = fetch_en;
          end else begin
            m_holding = 1; m_inst = mem_rdata; m_ipc = m_pc;
          end
        end else if (redirect_valid) begin
          m_stale = 1;
        end
      end else if (m_holding) begin
        if (redirect_valid) begin
          m_holding = 0; m_requesting = 1;
        end else if (out_ready) begin
          m_holding = 0; m_requesting = fetch_en;
        end
      end else if (fetch_en && !redirect_valid) begin
        m_requesting = 1;
      end
      m_pc = next_pc;
    end
  end

  always @(negedge clk) begin
    check("model_mem_req",   {63'd0, mem_req},   {63'd0, m_requesting});
    check("model_mem_addr",  mem_addr,           m_pc);
    check("model_out_valid", {63'd0, out_valid}, {63'd0, m_holding});
    check("model_busy",      {63'd0, busy},      {63'd0, m_requesting | m_awaiting});
    if (m_holding) begin
      check("model_out_inst", {32'd0, out_inst}, {32'd0, m_inst});
      check("model_out_pc",   out_pc,            m_ipc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; fetch_en = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    cyc(); cyc();
    check("rst_mem_req",   {63'd0, mem_req},   64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_mem_addr",  mem_addr,           RST_PC);
    check("rst_out_inst",  {32'd0, out_inst},  64'd0);
    check("rst_out_pc",    out_pc,             64'd0);
    rst_n = 1;
    cyc();

    // Basic fetch with immediate grant and next-cycle data
    fetch_en = 1;
    cyc();
    check("s1_req",   {63'd0, mem_req}, 64'd1);
    check("s1_addr0", mem_addr, 64'h8000_0000);
    mem_gnt = 1; cyc(); mem_gnt = 0;
    check("s1_busy_wait", {63'd0, busy}, 64'd1);
    mem_rvalid = 1; mem_rdata = 32'h0000_0013; cyc(); mem_rvalid = 0;
    check("s1_out_valid", {63'd0, out_valid}, 64'd1);
    check("s1_out_pc",    out_pc, 64'h8000_0000);
    check("s1_out_inst",  {32'd0, out_inst}, 64'h13);
    out_ready = 1; cyc(); out_ready = 0;
    check("s1_valid_drop", {63'd0, out_valid}, 64'd0);
    check("s1_addr1",      mem_addr, 64'h8000_0004);

    // Decode stalls for five cycles
    mem_gnt = 1; cyc(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h00A0_0093; cyc(); mem_rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check("s2_hold_inst", {32'd0, out_inst}, 64'h00A0_0093);
      check("s2_hold_pc",   out_pc, 64'h8000_0004);
      check("s2_no_req",    {63'd0, mem_req}, 64'd0);
      check("s2_pc_same",   mem_addr, 64'h8000_0004);
      cyc();
    end
    out_ready = 1; cyc(); out_ready = 0;
    check("s2_next_addr", mem_addr, 64'h8000_0008);

    // Redirect while waiting squashes the response
    mem_gnt = 1; cyc(); mem_gnt = 0;
    redirect_valid = 1; redirect_pc = 64'h8000_0103; cyc(); redirect_valid = 0;
    check("s3_aligned", mem_addr, 64'h8000_0100);
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; cyc(); mem_rvalid = 0;
    check("s3_no_valid", {63'd0, out_valid}, 64'd0);
    check("s3_rereq",    {63'd0, mem_req}, 64'd1);
    check("s3_addr",     mem_addr, 64'h8000_0100);

    // Redirect beats out_ready in HOLD
    mem_gnt = 1; cyc(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h0000_0013; cyc(); mem_rvalid = 0;
    check("s4_hold_pc", out_pc, 64'h8000_0100);
    redirect_valid = 1; redirect_pc = 64'h8000_1000; out_ready = 1; cyc();
    redirect_valid = 0; out_ready = 0;
    check("s4_dropped", {63'd0, out_valid}, 64'd0);
    check("s4_addr",    mem_addr, 64'h8000_1000);

    // Address wrap; redirect in REQ before grant moves the address
    redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; cyc(); redirect_valid = 0;
    check("s5_req_kept", {63'd0, mem_req}, 64'd1);
    check("s5_addr_top", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    mem_gnt = 1; cyc(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h0000_0001; cyc(); mem_rvalid = 0;
    check("s5_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    out_ready = 1; cyc(); out_ready = 0;
    check("s5_wrap", mem_addr, 64'h0);

    // fetch_en low completes the transaction, then idles
    fetch_en = 0;
    mem_gnt = 1; cyc(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h0000_0002; cyc(); mem_rvalid = 0;
    check("s5_hold_no_en", {63'd0, out_valid}, 64'd1);
    out_ready = 1; cyc(); out_ready = 0;
    check("s5_idle_req",  {63'd0, mem_req}, 64'd0);
    check("s5_idle_busy", {63'd0, busy}, 64'd0);
    check("s5_idle_addr", mem_addr, 64'h4);
    redirect_valid = 1; redirect_pc = 64'h8000_2002; cyc(); redirect_valid = 0;
    check("s5_idle_redir", mem_addr, 64'h8000_2000);
    mem_rvalid = 1; cyc(); mem_rvalid = 0;
    check("s5_stray_rvalid", {63'd0, out_valid}, 64'd0);

    // Reset mid-transaction, then a stray response
    fetch_en = 1; cyc();
    check("s6_addr", mem_addr, 64'h8000_2000);
    mem_gnt = 1; cyc(); mem_gnt = 0;
    check("s6_wait_busy", {63'd0, busy}, 64'd1);
    fetch_en = 0;
    #2 rst_n = 0;
    #1;
    check("s6_async_busy", {63'd0, busy}, 64'd0);
    check("s6_async_addr", mem_addr, RST_PC);
    cyc();
    rst_n = 1;
    mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0; cyc(); mem_rvalid = 0;
    check("s6_valid",    {63'd0, out_valid}, 64'd0);
    check("s6_busy",     {63'd0, busy}, 64'd0);
    check("s6_addr_rst", mem_addr, RST_PC);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be: RESET_PC, 64'h0000_0000_8000_0000, PC loaded at reset; XLEN, 64, PC/address width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- fetch_en  in  1  permit new fetches
- mem_req  out  1  instruction-memory request
- mem_addr  out  XLEN  request address
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  instruction word
- redirect_valid  in  1  branch/jump/trap redirect
- redirect_pc  in  XLEN  redirect target
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_inst  out  32  held instruction
- out_pc  out  XLEN  PC of out_inst
- busy  out  1  transaction outstanding (state REQ or WAIT)

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, HOLD, with one transaction outstanding at most.
REQ-005 IDLE: outputs quiet; fetch_en=1 -> REQ next cycle.
REQ-006 REQ: mem_req=1, mem_addr=pc; mem_gnt=1 -> WAIT; otherwise stay.
REQ-007 WAIT: mem_req=0; mem_rvalid=1 with no squash pending -> capture out_inst<=mem_rdata, out_pc<=pc, go to HOLD.
REQ-008 HOLD: out_valid=1; out_ready=1 -> pc<=pc+4, then REQ if fetch_en=1, else IDLE.
REQ-009 Latency: fetch_en rising in IDLE at cycle 0 -> mem_req at cycle 1; gnt at 1 and rvalid at 2 -> out_valid at 3.
REQ-010 PC arithmetic SHALL be XLEN-bit modulo 2^XLEN: pc 64'hFFFF_FFFF_FFFF_FFFC + 4 -> 0.
REQ-011 On redirect_valid, pc SHALL load {redirect_pc[XLEN-1:2],2'b00} at the next edge, in every state.
REQ-012 Redirect in IDLE: pc updates; state stays IDLE.
REQ-013 Redirect in REQ without gnt: stay REQ; mem_addr shows the new pc next cycle. The memory contract permits address change before gnt.
REQ-014 Redirect in REQ with gnt in the same cycle: go to WAIT with squash set.
REQ-015 Redirect in WAIT (before or with rvalid): set squash. The squashed response is discarded on arrival, squash clears, and the FSM goes to REQ. If rvalid arrives in the same cycle, go directly to REQ.
REQ-016 Redirect in HOLD SHALL take priority over out_ready: the held instruction is dropped, out_valid=0 next cycle, FSM goes to REQ, and pc is not incremented.
REQ-017 A redirect while squash is already set SHALL update pc only; a single squash bit suffices.
REQ-018 fetch_en=0 SHALL not abort an outstanding transaction. The block completes to HOLD, then goes to IDLE after acceptance. A squash-completion with fetch_en=0 goes to IDLE.
REQ-019 mem_rvalid outside WAIT SHALL be ignored.
REQ-020 out_inst/out_pc SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 All outputs SHALL be driven from registers or state decode only, with no combinational path from mem_rdata.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, squash=0, out_inst=0, out_pc=0.
REQ-023 During and after reset: mem_req=0, out_valid=0, busy=0, and mem_addr=RESET_PC.
REQ-024 Reset asserted mid-transaction SHALL abandon it. The first mem_rvalid after reset release SHALL be ignored because the state is IDLE.

Structure
REQ-025 RESET_PC, XLEN and the FSM state encoding (2-bit) SHALL live in the shared defines file.
REQ-026 The block SHALL be a single module with no sub-module; the PC, FSM, squash bit and output registers stay local.

Verification
REQ-027 Scenario: reset release, fetch_en=1, gnt immediate, rvalid next cycle with data 32'h0000_0013, out_ready=1 -> mem_addr 8000_0000, then 8000_0004. out_valid is 1 for one cycle with out_pc=8000_0000.
REQ-028 Scenario: HOLD with out_ready=0 for 5 cycles -> out_inst/out_pc constant, no mem_req, pc unchanged.
REQ-029 Scenario: redirect to 8000_0103 during WAIT, then rvalid 32'hDEAD_BEEF -> no out_valid for that data, next mem_addr=8000_0100.
REQ-030 Scenario: redirect and out_ready together in HOLD, target 8000_1000 -> held instruction dropped, next mem_addr=8000_1000.
REQ-031 Scenario: pc=FFFF_FFFF_FFFF_FFFC accepted -> next mem_addr=0.
REQ-032 Scenario: rst_n low while in WAIT, then stray rvalid after release -> state IDLE, out_valid=0, pc=RESET_PC.
